// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the AXI-Stream UART transmit arbiter.
//   arb_state_t  : arbiter FSM encoding (ARB_HDR only reachable with ARB_SRC_ID_EN)
//   rr_pick      : rotate-priority search, first valid index after 'last'
//   arb_hdr_beat : source-id header byte, id zero-extended to 8 bits
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HDR  = 2'd1,
    ARB_XFER = 2'd2
  } arb_state_t;

  // Upper bound on requesters; fixes the width of the search vectors below.
  localparam int unsigned ARB_MAX_SRC = 16;
  localparam int unsigned ARB_IDX_W   = 4;
  // Zero bits placed above the id field to fill an 8-bit header byte.
  localparam int unsigned ARB_HDR_PAD = 8 - ARB_IDX_W;

  // Scan last+1, last+2, ... (mod num_src) and return the first valid index.
  // Returns 0 when nothing is valid; callers qualify the result with |valid.
  function automatic logic [ARB_IDX_W-1:0] rr_pick(input logic [ARB_MAX_SRC-1:0] valid,
                                                   input logic [ARB_IDX_W-1:0]   last,
                                                   input int unsigned            num_src);
    logic [ARB_IDX_W-1:0] pick;
    logic [ARB_IDX_W-1:0] idx;
    logic                 found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= ARB_MAX_SRC; i++) begin
      idx = ARB_IDX_W'((32'(last) + i) % num_src);
      if (!found && (i <= num_src) && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [7:0] arb_hdr_beat(input logic [ARB_IDX_W-1:0] id);
    return {{ARB_HDR_PAD{1'b0}}, id};
  endfunction

endpackage

// File: rtl/axis_uart_tx_arbiter_if.sv
// Bundle of the requester-side and transceiver-side AXI-Stream signals of the arbiter.
//   s_axis_* : NUM_SRC requester streams, source i data in [i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_* : single stream towards the UART transceiver s_axis port
// Modports: slave  = the arbiter (consumes s_axis, produces m_axis)
//           master = the surrounding system (produces s_axis, consumes m_axis)
interface axis_uart_tx_arbiter_if #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_WIDTH = 8
);

  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]            s_axis_tvalid;
  logic [NUM_SRC-1:0]            s_axis_tlast;
  logic [NUM_SRC-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Round-robin pick with a registered last-granted pointer.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   req           : one request bit per source
//   advance       : a grant is taken this cycle; pointer moves to 'pick'
//   pick          : first requesting index after the last grant (valid when any=1)
//   any           : at least one request present
module uart_rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned IdxW    = $clog2(NUM_SRC)
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [NUM_SRC-1:0] req,
  input  logic               advance,
  output logic [IdxW-1:0]    pick,
  output logic               any
);

  logic [IdxW-1:0] r_last;

  assign pick = IdxW'(rr_pick(ARB_MAX_SRC'(req), ARB_IDX_W'(r_last), NUM_SRC));
  assign any  = |req;

  // Starting at NUM_SRC-1 makes source 0 the first in line after reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_last <= IdxW'(NUM_SRC - 1);
    end else if (advance) begin
      r_last <= pick;
    end
  end

endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// Shares one AXI-Stream UART transmit input among NUM_SRC requester streams.
// Round-robin, packet-granular: a grant ends on an accepted tlast beat or on the
// MAX_BURST-th accepted beat. One idle arbitration cycle separates grants.
// Optional macro ARB_SRC_ID_EN: each grant first emits a header beat carrying the
// granted source index (zero-extended), then the payload.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   bus           : slave modport, s_axis_* requesters and m_axis_* to transceiver
//   grant_id      : current or last granted source index
//   busy          : a grant is held
module axis_uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC    = 4,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned MAX_BURST  = 16,
  localparam int unsigned IdxW       = $clog2(NUM_SRC),
  localparam int unsigned CntW       = $clog2(MAX_BURST + 1)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axis_uart_tx_arbiter_if.slave bus,
  output logic [IdxW-1:0]       grant_id,
  output logic                  busy
);

  arb_state_t            r_state;
  arb_state_t            w_state_next;
  logic [IdxW-1:0]       r_grant_id;
  logic [CntW-1:0]       r_beat_cnt;
  logic [IdxW-1:0]       w_pick;
  logic                  w_any;
  logic                  w_grant;
  logic                  w_accept;
  logic                  w_end;
  logic [DATA_WIDTH-1:0] w_src_data [NUM_SRC];
  logic [DATA_WIDTH-1:0] w_m_tdata;
  logic                  w_m_tvalid;
  logic [NUM_SRC-1:0]    w_s_tready;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slice
    assign w_src_data[g] = bus.s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  uart_rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_rr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .req     (bus.s_axis_tvalid),
    .advance (w_grant),
    .pick    (w_pick),
    .any     (w_any)
  );

  assign w_grant  = (r_state == ARB_IDLE) && w_any;
  assign w_accept = (r_state == ARB_XFER) && w_m_tvalid && bus.m_axis_tready;
  // Count compare uses the pre-increment value: this accept brings it to MAX_BURST.
  assign w_end    = w_accept &&
                    (bus.s_axis_tlast[r_grant_id] || (r_beat_cnt == CntW'(MAX_BURST - 1)));

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
`ifdef ARB_SRC_ID_EN
          w_state_next = ARB_HDR;
`else
          w_state_next = ARB_XFER;
`endif
        end
      end
`ifdef ARB_SRC_ID_EN
      ARB_HDR: begin
        if (bus.m_axis_tready) begin
          w_state_next = ARB_XFER;
        end
      end
`endif
      ARB_XFER: begin
        if (w_end) begin
          w_state_next = ARB_IDLE;
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  // Output logic: pass-through of the granted source while in XFER.
  always_comb begin
    w_m_tdata  = '0;
    w_m_tvalid = 1'b0;
    w_s_tready = '0;
    unique case (r_state)
`ifdef ARB_SRC_ID_EN
      ARB_HDR: begin
        w_m_tdata  = DATA_WIDTH'(arb_hdr_beat(ARB_IDX_W'(r_grant_id)));
        w_m_tvalid = 1'b1;
      end
`endif
      ARB_XFER: begin
        w_m_tdata              = w_src_data[r_grant_id];
        w_m_tvalid             = bus.s_axis_tvalid[r_grant_id];
        w_s_tready[r_grant_id] = bus.m_axis_tready;
      end
      default: ;
    endcase
  end

  // Grant index and beat counter; both reload at every new grant.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else if (w_grant) begin
      r_grant_id <= w_pick;
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

  assign bus.m_axis_tdata  = w_m_tdata;
  assign bus.m_axis_tvalid = w_m_tvalid;
  assign bus.s_axis_tready = w_s_tready;
  assign grant_id          = r_grant_id;
  assign busy              = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Directed bench for axis_uart_tx_arbiter (NUM_SRC=4, DATA_WIDTH=8, MAX_BURST=16).
module tb_axis_uart_tx_arbiter;

  localparam int NumSrc = 4;
  localparam int DataW  = 8;
`ifdef ARB_SRC_ID_EN
  localparam int Gap = 3;  // IDLE + HDR before each payload
`else
  localparam int Gap = 2;  // one IDLE bubble between grants
`endif

  typedef struct {
    int         cyc;
    logic [1:0] gid;
    logic [7:0] data;
  } beat_t;

  logic       aclk;
  logic       aresetn;
  logic [1:0] grant_id;
  logic       busy;

  logic [NumSrc*DataW-1:0] drv_tdata;
  logic [NumSrc-1:0]       drv_tvalid;
  logic [NumSrc-1:0]       drv_tlast;
  logic                    drv_ready;
  logic [NumSrc-1:0]       hs;

  logic [8:0] src_q [NumSrc][$];  // {tlast, tdata}
  logic       rdy_q [$];
  beat_t      out_q [$];
  beat_t      hdr_q [$];

  int cyc;
  int n_checks;
  int n_fail;
  int err_onehot;
  int err_stable;
  logic       prev_stall;
  logic [7:0] prev_data;

  axis_uart_tx_arbiter_if #(.NUM_SRC(NumSrc), .DATA_WIDTH(DataW)) bus ();

  assign bus.s_axis_tdata  = drv_tdata;
  assign bus.s_axis_tvalid = drv_tvalid;
  assign bus.s_axis_tlast  = drv_tlast;
  assign bus.m_axis_tready = drv_ready;

  axis_uart_tx_arbiter #(
    .NUM_SRC    (NumSrc),
    .DATA_WIDTH (DataW),
    .MAX_BURST  (16)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Source driver: pop handshaken beats, present queue heads, apply ready pattern.
  initial begin : driver
    logic [8:0] e;
    forever begin
      @(posedge aclk);
      #1;
      for (int i = 0; i < NumSrc; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          e = src_q[i][0];
          drv_tvalid[i] = 1'b1;
          drv_tlast[i]  = e[8];
          drv_tdata[i*DataW +: DataW] = e[7:0];
        end else begin
          drv_tvalid[i] = 1'b0;
          drv_tlast[i]  = 1'b0;
        end
      end
      hs = '0;
      if (rdy_q.size() > 0) drv_ready = rdy_q.pop_front();
      else drv_ready = 1'b1;
    end
  end

  // Monitor: record accepted beats, watch ready one-hot and stall stability.
  initial begin : monitor
    forever begin
      @(negedge aclk);
      hs = drv_tvalid & bus.s_axis_tready;
      if (aresetn) begin
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          if (bus.s_axis_tready != '0) out_q.push_back('{cyc, grant_id, bus.m_axis_tdata});
          else hdr_q.push_back('{cyc, grant_id, bus.m_axis_tdata});
        end
        if (bus.s_axis_tready != '0 && bus.s_axis_tready != (4'b0001 << grant_id)) err_onehot++;
        if (prev_stall && (!bus.m_axis_tvalid || bus.m_axis_tdata != prev_data)) err_stable++;
        prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
        prev_data  = bus.m_axis_tdata;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    aresetn = 1'b0;
    for (int i = 0; i < NumSrc; i++) src_q[i].delete();
    rdy_q.delete();
    repeat (2) @(negedge aclk);
    #2;
    aresetn = 1'b1;
    out_q.delete();
    hdr_q.delete();
    @(posedge aclk);
    #2;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (out_q.size() < n && k < budget) begin
      @(negedge aclk);
      #1;
      k++;
    end
    check_eq({tag, "_count"}, 32'(out_q.size()), 32'(n));
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [1:0] gid,
                            input logic [7:0] data, input bit chk_data);
    if (idx < out_q.size()) begin
      check_eq({tag, "_gid"}, 32'(out_q[idx].gid), 32'(gid));
      if (chk_data) check_eq({tag, "_data"}, 32'(out_q[idx].data), 32'(data));
    end else begin
      check_eq({tag, "_missing"}, 32'(out_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_gap(input string tag, input int i, input int j, input int exp);
    if (j < out_q.size()) check_eq(tag, 32'(out_q[j].cyc - out_q[i].cyc), 32'(exp));
    else check_eq({tag, "_missing"}, 32'(out_q.size()), 32'(j + 1));
  endtask

  initial begin : stim
    n_checks = 0; n_fail = 0; err_onehot = 0; err_stable = 0;
    prev_stall = 1'b0; prev_data = '0;
    aresetn = 1'b0; drv_tdata = '0; drv_tvalid = '0; drv_tlast = '0; drv_ready = 1'b1;
    hs = '0;

    // Reset values
    repeat (2) @(negedge aclk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_grant_id", 32'(grant_id), 32'(0));
    check_eq("rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'(0));
    check_eq("rst_m_tdata", 32'(bus.m_axis_tdata), 32'(0));
    check_eq("rst_s_tready", 32'(bus.s_axis_tready), 32'(0));

    // 1: src0 three-beat packet
    do_reset();
    src_q[0].push_back({1'b0, 8'h11});
    src_q[0].push_back({1'b0, 8'h22});
    src_q[0].push_back({1'b1, 8'h33});
    @(negedge aclk); #1;
    @(negedge aclk); #1;
    check_eq("t1_tvalid_seen", 32'(drv_tvalid[0]), 32'(1));
    check_eq("t1_busy_before", 32'(busy), 32'(0));
    check_eq("t1_idle_m_tvalid", 32'(bus.m_axis_tvalid), 32'(0));
    @(negedge aclk); #1;
    check_eq("t1_busy_rise", 32'(busy), 32'(1));
`ifdef ARB_SRC_ID_EN
    check_eq("t1_hdr_now", 32'(hdr_q.size()), 32'(1));
`else
    check_eq("t1_first_beat_now", 32'(out_q.size()), 32'(1));
`endif
    wait_beats("t1", 3, 20);
    check_beat("t1_b0", 0, 2'd0, 8'h11, 1'b1);
    check_beat("t1_b1", 1, 2'd0, 8'h22, 1'b1);
    check_beat("t1_b2", 2, 2'd0, 8'h33, 1'b1);
    check_gap("t1_gap01", 0, 1, 1);
    check_gap("t1_gap12", 1, 2, 1);
    @(negedge aclk); #1;
    check_eq("t1_busy_after", 32'(busy), 32'(0));
    check_eq("t1_grant_hold", 32'(grant_id), 32'(0));

    // 2: all sources request one-beat packets, src0 has a second one queued
    do_reset();
    src_q[0].push_back({1'b1, 8'hA0});
    src_q[0].push_back({1'b1, 8'hB0});
    src_q[1].push_back({1'b1, 8'hA1});
    src_q[2].push_back({1'b1, 8'hA2});
    src_q[3].push_back({1'b1, 8'hA3});
    wait_beats("t2", 5, 40);
    check_beat("t2_b0", 0, 2'd0, 8'hA0, 1'b1);
    check_beat("t2_b1", 1, 2'd1, 8'hA1, 1'b1);
    check_beat("t2_b2", 2, 2'd2, 8'hA2, 1'b1);
    check_beat("t2_b3", 3, 2'd3, 8'hA3, 1'b1);
    check_beat("t2_b4", 4, 2'd0, 8'hB0, 1'b1);
    for (int i = 0; i < 4; i++) check_gap("t2_gap", i, i + 1, Gap);

    // 3: src2 streams 40 beats without tlast, src1 arrives later
    do_reset();
    for (int i = 0; i < 40; i++) src_q[2].push_back({1'b0, 8'(i)});
    repeat (5) @(posedge aclk);
    #2;
    src_q[1].push_back({1'b1, 8'h5A});
    wait_beats("t3", 41, 300);
    check_beat("t3_first", 0, 2'd2, 8'd0, 1'b1);
    check_beat("t3_b15", 15, 2'd2, 8'd15, 1'b1);
    check_beat("t3_src1", 16, 2'd1, 8'h5A, 1'b1);
    check_beat("t3_resume", 17, 2'd2, 8'd16, 1'b1);
    check_beat("t3_b32", 32, 2'd2, 8'd31, 1'b1);
    check_beat("t3_rot2", 33, 2'd2, 8'd32, 1'b1);
    check_beat("t3_last", 40, 2'd2, 8'd39, 1'b1);
    check_gap("t3_gap_burst", 15, 16, Gap);
    check_gap("t3_gap_same_src", 32, 33, Gap);
    repeat (2) @(negedge aclk);
    #1;
    check_eq("t3_hold_busy", 32'(busy), 32'(1));
    check_eq("t3_hold_m_tvalid", 32'(bus.m_axis_tvalid), 32'(0));
    check_eq("t3_hold_s_tready", 32'(bus.s_axis_tready), 32'(4'b0100));

    // 4: ready toggling during a 4-beat packet with a competing source
    do_reset();
    err_onehot = 0;
    err_stable = 0;
    rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    src_q[0].push_back({1'b0, 8'hC1});
    src_q[0].push_back({1'b0, 8'hC2});
    src_q[0].push_back({1'b0, 8'hC3});
    src_q[0].push_back({1'b1, 8'hC4});
    src_q[1].push_back({1'b1, 8'hD1});
    wait_beats("t4", 5, 40);
    check_beat("t4_b0", 0, 2'd0, 8'hC1, 1'b1);
    check_beat("t4_b1", 1, 2'd0, 8'hC2, 1'b1);
    check_beat("t4_b2", 2, 2'd0, 8'hC3, 1'b1);
    check_beat("t4_b3", 3, 2'd0, 8'hC4, 1'b1);
    check_beat("t4_b4", 4, 2'd1, 8'hD1, 1'b1);
    check_eq("t4_onehot_errs", 32'(err_onehot), 32'(0));
    check_eq("t4_stall_errs", 32'(err_stable), 32'(0));

    // 5: reset on beat 2 of a 5-beat src2 packet
    do_reset();
    src_q[2].push_back({1'b0, 8'hE1});
    src_q[2].push_back({1'b0, 8'hE2});
    src_q[2].push_back({1'b0, 8'hE3});
    src_q[2].push_back({1'b0, 8'hE4});
    src_q[2].push_back({1'b1, 8'hE5});
    wait_beats("t5_pre", 1, 20);
    @(negedge aclk);
    #2;
    check_eq("t5_beat2_on_bus", 32'(bus.m_axis_tdata), 32'(8'hE2));
    check_eq("t5_grant2", 32'(grant_id), 32'(2));
    aresetn = 1'b0;
    #1;
    check_eq("t5_async_busy", 32'(busy), 32'(0));
    check_eq("t5_async_m_tvalid", 32'(bus.m_axis_tvalid), 32'(0));
    check_eq("t5_async_m_tdata", 32'(bus.m_axis_tdata), 32'(0));
    check_eq("t5_async_s_tready", 32'(bus.s_axis_tready), 32'(0));
    check_eq("t5_async_grant_id", 32'(grant_id), 32'(0));
    src_q[0].push_back({1'b1, 8'hF0});
    src_q[3].push_back({1'b1, 8'h3C});
    @(negedge aclk);
    #2;
    aresetn = 1'b1;
    out_q.delete();
    hdr_q.delete();
    wait_beats("t5_post", 2, 40);
    check_beat("t5_post_b0", 0, 2'd0, 8'hF0, 1'b1);
    check_beat("t5_post_b1", 1, 2'd2, 8'h00, 1'b0);

`ifdef ARB_SRC_ID_EN
    // 6: source-id header ahead of the payload
    do_reset();
    src_q[3].push_back({1'b1, 8'hAB});
    wait_beats("t6", 1, 20);
    check_eq("t6_hdr_count", 32'(hdr_q.size()), 32'(1));
    if (hdr_q.size() > 0) begin
      check_eq("t6_hdr_data", 32'(hdr_q[0].data), 32'(8'h03));
      check_eq("t6_hdr_to_payload", 32'(out_q[0].cyc - hdr_q[0].cyc), 32'(1));
    end
    check_beat("t6_payload", 0, 2'd3, 8'hAB, 1'b1);
`endif

    check_eq("global_onehot_errs", 32'(err_onehot), 32'(0));
    check_eq("global_stall_errs", 32'(err_stable), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
